bus_master: RTL and testbench

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_timer.sv | 42 ++++
 rtl/bus_master.sv | 175 +++++++++++++++++
 tb/tb_bus_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus_master slice.
//   - Slave register map (control, operand A, operand B) and control go value.
//   - Timer width used by bus_timer.
//   - FSM state enumeration for bus_master.
//   - zext16: zero-extends a 16-bit operand onto the 32-bit write bus.
package bus_pkg;

  localparam logic [4:0]  ADR_CTRL = 5'd0;
  localparam logic [4:0]  ADR_A    = 5'd1;
  localparam logic [4:0]  ADR_B    = 5'd2;
  localparam logic [31:0] CTRL_GO  = 32'h0000_0001;

  // Wide enough for any TIMEOUT in 1..65535.
  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_A  = 3'd1,
    ST_WR_B  = 3'd2,
    ST_WR_GO = 3'd3,
    ST_ARM   = 3'd4,
    ST_WAIT  = 3'd5,
    ST_RD    = 3'd6,
    ST_DONE  = 3'd7
  } bus_state_e;

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/bus_timer.sv
// bus_timer: WAIT-state watchdog counter for bus_master.
// Only instantiated when BUS_MASTER_TIMEOUT_EN is defined.
// Ports:
//   i_clk     rising-edge clock
//   i_rst     asynchronous active-high reset (count -> 0)
//   i_clear   synchronous clear, has priority over i_enable
//   i_enable  count one per cycle while high
//   o_tc      terminal count: high during the TIMEOUT-th enabled cycle
import bus_pkg::*;

module bus_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  // Count starts at 0 in the first enabled cycle, so the TIMEOUT-th cycle
  // sees TIMEOUT-1 and the FSM leaves on that cycle's closing edge.
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_count;

  // Cycle counter: cleared outside WAIT, advancing inside it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {TMR_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {TMR_W{1'b0}};
    end else if (i_enable) begin
      r_count <= r_count + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = i_enable && (r_count == LAST);

endmodule

// File: rtl/bus_master.sv
// bus_master: drives a multiply slave over a simple write bus.
// Sequence: write op_a (adr 1), op_b (adr 2), go bit (adr 0), wait for
// ready, read the product from r_adr, then pulse done with the result.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, op_a, op_b  host request and operands (start honoured in IDLE only)
//   busy, done         status: not-IDLE, one-cycle completion pulse
//   result, err        product and timeout flag, updated on DONE entry
//   signal, w_adr, w_data  bus write strobe, address and data
//   r_adr, r_data      result address (RESULT_ADR) and read data
//   ready              slave completion, honoured in WAIT only
// Optional feature: define BUS_MASTER_TIMEOUT_EN to bound WAIT at TIMEOUT
// cycles (exit to DONE with err=1, result unchanged). Without it WAIT is
// unbounded and err stays 0.
import bus_pkg::*;

module bus_master #(
  parameter int TIMEOUT    = 255,
  parameter int RESULT_ADR = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic        signal,
  output logic [4:0]  w_adr,
  output logic [31:0] w_data,
  output logic [4:0]  r_adr,
  input  logic [31:0] r_data,
  input  logic        ready
);

  bus_state_e  r_state;
  bus_state_e  w_next;
  logic        w_timeout;
  logic        w_tc;
  logic [15:0] r_op_b;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_err;
  logic        r_signal;
  logic [4:0]  r_wadr;
  logic [31:0] r_wdata;
  logic [4:0]  r_radr;
  logic        w_signal;
  logic [4:0]  w_wadr;
  logic [31:0] w_wdata;

`ifdef BUS_MASTER_TIMEOUT_EN
  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (r_state != ST_WAIT),
    .i_enable (r_state == ST_WAIT),
    .o_tc     (w_tc)
  );
`else
  assign w_tc = 1'b0;
`endif

  // Next-state decode; ready wins over a coincident timeout.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_WR_A;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WR_A:  w_next = ST_WR_B;
      ST_WR_B:  w_next = ST_WR_GO;
      ST_WR_GO: w_next = ST_ARM;
      ST_ARM:   w_next = ST_WAIT;
      ST_WAIT: begin
        if (ready) begin
          w_next = ST_RD;
        end else if (w_tc) begin
          w_next    = ST_DONE;
          w_timeout = 1'b1;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_RD:    w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Bus values for the state being entered, so the registered bus matches
  // the current state. WR_A is only reached from IDLE on the accepting edge,
  // so op_a goes straight onto the bus and needs no holding register.
  always_comb begin
    w_signal = 1'b0;
    w_wadr   = ADR_CTRL;
    w_wdata  = 32'h0000_0000;
    case (w_next)
      ST_WR_A: begin
        w_signal = 1'b1;
        w_wadr   = ADR_A;
        w_wdata  = zext16(op_a);
      end
      ST_WR_B: begin
        w_signal = 1'b1;
        w_wadr   = ADR_B;
        w_wdata  = zext16(r_op_b);
      end
      ST_WR_GO: begin
        w_signal = 1'b1;
        w_wadr   = ADR_CTRL;
        w_wdata  = CTRL_GO;
      end
      default: begin
        w_signal = 1'b0;
        w_wadr   = ADR_CTRL;
        w_wdata  = 32'h0000_0000;
      end
    endcase
  end

  // State, operand latch and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op_b   <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'h0000_0000;
      r_err    <= 1'b0;
      r_signal <= 1'b0;
      r_wadr   <= 5'd0;
      r_wdata  <= 32'h0000_0000;
      r_radr   <= 5'(RESULT_ADR);
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != ST_IDLE);
      r_done   <= (w_next == ST_DONE);
      r_signal <= w_signal;
      r_wadr   <= w_wadr;
      r_wdata  <= w_wdata;
      r_radr   <= 5'(RESULT_ADR);
      if ((r_state == ST_IDLE) && start) begin
        r_op_b <= op_b;
      end
      // RD always exits to DONE, so this is the DONE-entry edge.
      if (r_state == ST_RD) begin
        r_result <= r_data;
        r_err    <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;
  assign signal = r_signal;
  assign w_adr  = r_wadr;
  assign w_data = r_wdata;
  assign r_adr  = r_radr;

endmodule

// File: tb/tb_bus_master.sv
module tb_bus_master;

  typedef struct {
    logic [4:0]  adr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } dn_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic        signal;
  logic [4:0]  w_adr;
  logic [31:0] w_data;
  logic [4:0]  r_adr;
  logic [31:0] r_data;
  logic        ready;

  // behavioural slave
  logic [15:0] s_a;
  logic [15:0] s_b;
  int          s_cnt;
  logic        s_ready;
  int          slave_delay;
  bit          slave_mute;
  logic        stray;

  wr_t wq[$];
  dn_t dq[$];
  int  n_tests;
  int  n_fail;
  int  n_done;
  int  exp_done;

  bus_master #(
    .TIMEOUT    (16),
    .RESULT_ADR (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .signal (signal),
    .w_adr  (w_adr),
    .w_data (w_data),
    .r_adr  (r_adr),
    .r_data (r_data),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ready  = s_ready | stray;
  assign r_data = 32'(s_a) * 32'(s_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // slave: latches operands, counts down after the go write, pulses ready
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt   <= 0;
      s_ready <= 1'b0;
    end else begin
      if (signal && w_adr == 5'd1) s_a <= w_data[15:0];
      if (signal && w_adr == 5'd2) s_b <= w_data[15:0];
      if (signal && w_adr == 5'd0 && w_data == 32'h1 && !slave_mute) s_cnt <= slave_delay;
      else if (s_cnt != 0) s_cnt <= s_cnt - 1;
      s_ready <= (s_cnt == 1);
    end
  end

  // monitor: pops expectations whenever the DUT writes or completes
  always @(negedge clk) begin
    if (!rst) begin
      if (signal) begin
        if (wq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got adr %0d data %h expected no write", w_adr, w_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("write_adr", 32'(w_adr), 32'(e.adr));
          chk("write_data", w_data, e.data);
        end
      end
      if (done) begin
        n_done++;
        if (dq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done with result %h expected none", result);
        end else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_result", result, d.res);
          chk("done_err", 32'(err), 32'(d.err));
        end
      end
    end
  end

  task automatic push_writes(input logic [15:0] a, input logic [15:0] b);
    wq.push_back('{adr: 5'd1, data: {16'h0, a}});
    wq.push_back('{adr: 5'd2, data: {16'h0, b}});
    wq.push_back('{adr: 5'd0, data: 32'h1});
  endtask

  // mode 0: plain, 1: re-pulse start with op_a=7 two cycles in, 2: stray ready in ARM.
  // Returns in the DONE cycle.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int dly,
                         input bit mute, input logic [31:0] exp_res, input bit exp_err,
                         input int exp_lat, input int mode);
    int lat;
    bit seen;
    push_writes(a, b);
    dq.push_back('{res: exp_res, err: exp_err});
    exp_done++;
    slave_delay = dly;
    slave_mute  = mute;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
      if (mode == 1 && lat == 2) begin
        start = 1'b1;
        op_a  = 16'd7;
      end
      if (mode == 2) stray = (lat == 4);
      if (done) seen = 1'b1;
    end
    stray = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
    end else begin
      chk("latency", 32'(lat), 32'(exp_lat));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_done = 0; exp_done = 0;
    rst = 1'b1; start = 1'b0; op_a = 16'h0; op_b = 16'h0;
    stray = 1'b0; slave_delay = 1; slave_mute = 1'b0;
    s_a = 16'h0; s_b = 16'h0;
    #12;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_signal", 32'(signal), 32'h0);
    chk("rst_w_adr", 32'(w_adr), 32'h0);
    chk("rst_w_data", w_data, 32'h0);
    chk("rst_r_adr", 32'(r_adr), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_txn(16'd3, 16'd5, 10, 1'b0, 32'd15, 1'b0, 16, 0);
    @(posedge clk);
    run_txn(16'hFFFF, 16'hFFFF, 1, 1'b0, 32'hFFFE0001, 1'b0, 7, 2);
    @(posedge clk);
    run_txn(16'd12, 16'd11, 3, 1'b0, 32'd132, 1'b0, 9, 1);

    // start raised in the DONE cycle must not be seen
    start = 1'b1; op_a = 16'd7; op_b = 16'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("start_in_done_ignored_busy", 32'(busy), 32'h0);

    // ready while idle must be ignored
    stray = 1'b1;
    repeat (2) @(posedge clk);
    #1 stray = 1'b0;
    chk("stray_ready_idle_busy", 32'(busy), 32'h0);
    chk("result_hold", result, 32'd132);

`ifdef BUS_MASTER_TIMEOUT_EN
    run_txn(16'd9, 16'd9, 1, 1'b1, 32'd132, 1'b1, 21, 0);
    @(posedge clk);
    slave_mute = 1'b0;
`endif

    // reset during WAIT
    push_writes(16'd5, 16'd5);
    slave_delay = 50;
    @(negedge clk);
    start = 1'b1; op_a = 16'd5; op_b = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("pre_rst_busy_wait", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_wait_busy", 32'(busy), 32'h0);
    chk("rst_wait_signal", 32'(signal), 32'h0);
    chk("rst_wait_w_adr", 32'(w_adr), 32'h0);
    chk("rst_wait_w_data", w_data, 32'h0);
    chk("rst_wait_done", 32'(done), 32'h0);
    chk("rst_wait_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // reset during WR_B: only the operand A write is ever seen
    wq.push_back('{adr: 5'd1, data: 32'd4});
    @(negedge clk);
    start = 1'b1; op_a = 16'd4; op_b = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_signal_wrb", 32'(signal), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_wrb_signal", 32'(signal), 32'h0);
    chk("rst_wrb_w_adr", 32'(w_adr), 32'h0);
    chk("rst_wrb_w_data", w_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // back-to-back transactions after reset
    run_txn(16'd2, 16'd4, 2, 1'b0, 32'd8, 1'b0, 8, 0);
    @(posedge clk);
    run_txn(16'd6, 16'd7, 4, 1'b0, 32'd42, 1'b0, 10, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("write_queue_empty", 32'(wq.size()), 32'h0);
    chk("done_queue_empty", 32'(dq.size()), 32'h0);
    chk("done_pulse_count", 32'(n_done), 32'(exp_done));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
